hdlc_rx_deframer: RTL

Parametrised HDLC receive deframer. Takes a serial bit stream with a qualifying strobe and performs the following:
- detects flags, aborts and stuffed zeros for a configurable run length;
- strips the stuffed zeros;
- assembles payload into DATA_W-bit words, LSB first;
- reports per-frame length and status.

It sits between the line-side bit recovery logic and the frame buffer. It extends the fixed 6-ones flag detector with frame payload extraction.

---
 rtl/hdlc_rx_deframer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: HDLC receive deframer: flag/abort/stuff detection, zero stripping, LSB-first word assembly, frame status.
// Define HDLC_RX_FCS_EN to add the CRC-16-CCITT FCS check (status[3]).
module hdlc_rx_deframer #(
  parameter int DATA_W   = 8,
  parameter int MAX_ONES = 5,
  parameter int LEN_W    = 12
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_in_valid,
  input  logic              i_in,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_sof,
  output logic              o_frame_end,
  output logic [LEN_W-1:0]  o_frame_len,
  output logic [3:0]        o_frame_status,
  output logic              o_flag,
  output logic              o_disc,
  output logic              o_err
);
  localparam int DL = MAX_ONES + 2;
  localparam int OW = $clog2(MAX_ONES + 3);
  localparam int DW = $clog2(DL + 1);
  localparam int AW = $clog2(DATA_W + 1);

  typedef enum logic {HUNT, FRAME} state_t;

  state_t            r_state;
  logic [OW-1:0]     r_ones;
  logic [DL-1:0]     r_dl;
  logic [DW-1:0]     r_dl_cnt;
  logic [DATA_W-1:0] r_asm;
  logic [AW-1:0]     r_asm_cnt;
  logic [LEN_W-1:0]  r_len;
  logic              r_ovf;
  logic              w_abort, w_flag, w_stuff, w_push, w_grad, w_gbit, w_done, w_empty, w_fcs_err;
  logic [DATA_W-1:0] w_asm_nxt;

  assign w_abort   = i_in && r_ones == OW'(MAX_ONES + 1);
  assign w_flag    = !i_in && r_ones == OW'(MAX_ONES + 1);
  assign w_stuff   = !i_in && r_ones == OW'(MAX_ONES);
  assign w_push    = r_state == FRAME && !w_abort && !w_flag && !w_stuff;
  // the delay line keeps the flag's leading bits out of the payload
  assign w_grad    = w_push && r_dl_cnt == DW'(DL);
  assign w_gbit    = r_dl[DL-1];
  assign w_asm_nxt = (r_asm >> 1) | (DATA_W'(w_gbit) << (DATA_W - 1));
  assign w_done    = r_asm_cnt == AW'(DATA_W - 1);
  assign w_empty   = r_len == '0 && r_asm_cnt == '0;

`ifdef HDLC_RX_FCS_EN
  logic [15:0] r_crc;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_crc <= 16'hFFFF;
    else if (i_in_valid && w_flag) r_crc <= 16'hFFFF;
    else if (i_in_valid && w_grad) r_crc <= (r_crc >> 1) ^ ((r_crc[0] ^ w_gbit) ? 16'h8408 : 16'h0000);
  end
  assign w_fcs_err = r_crc != 16'hF0B8;
`else
  assign w_fcs_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= HUNT;
      r_ones         <= '0;
      r_dl           <= '0;
      r_dl_cnt       <= '0;
      r_asm          <= '0;
      r_asm_cnt      <= '0;
      r_len          <= '0;
      r_ovf          <= 1'b0;
      o_out_valid    <= 1'b0;
      o_out_data     <= '0;
      o_out_sof      <= 1'b0;
      o_frame_end    <= 1'b0;
      o_frame_len    <= '0;
      o_frame_status <= '0;
      o_flag         <= 1'b0;
      o_disc         <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      {o_out_valid, o_out_sof, o_frame_end, o_flag, o_disc, o_err} <= '0;
      if (i_in_valid) begin
        r_ones <= i_in ? (r_ones == OW'(MAX_ONES + 2) ? r_ones : r_ones + OW'(1)) : '0;
        o_err  <= w_abort;
        o_flag <= w_flag;
        if (w_flag) begin
          r_state   <= FRAME;
          r_dl      <= '0;
          r_dl_cnt  <= '0;
          r_asm     <= '0;
          r_asm_cnt <= '0;
          r_len     <= '0;
          r_ovf     <= 1'b0;
          if (r_state == FRAME && !w_empty) begin
            o_frame_end    <= 1'b1;
            o_frame_len    <= r_len;
            o_frame_status <= {w_fcs_err, r_ovf, r_asm_cnt != '0, 1'b0};
          end
        end else if (r_state == FRAME) begin
          if (w_abort) begin
            r_state        <= HUNT;
            o_frame_end    <= 1'b1;
            o_frame_len    <= r_len;
            o_frame_status <= {1'b0, r_ovf, 2'b01};
          end else if (w_stuff) begin
            o_disc <= 1'b1;
          end else begin
            r_dl <= {r_dl[DL-2:0], i_in};
            if (!w_grad) r_dl_cnt <= r_dl_cnt + DW'(1);
            if (w_grad) begin
              r_asm     <= w_asm_nxt;
              r_asm_cnt <= w_done ? '0 : r_asm_cnt + AW'(1);
              if (w_done && &r_len) begin
                r_ovf <= 1'b1;
              end else if (w_done) begin
                o_out_valid <= 1'b1;
                o_out_data  <= w_asm_nxt;
                o_out_sof   <= r_len == '0;
                r_len       <= r_len + LEN_W'(1);
              end
            end
          end
        end
      end
    end
  end
endmodule
